// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, SubBytes engine FSM states and
// the FIPS-197 byte-position helper.
package aes_pkg;

  localparam int unsigned AES_BLOCK_BITS  = 128;
  localparam int unsigned AES_BLOCK_BYTES = 16;
  localparam int unsigned BIT_IDX_W       = $clog2(AES_BLOCK_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_bytes_state_e;

  // LSB position of byte i in a block; byte 0 is the most significant byte.
  function automatic logic [BIT_IDX_W-1:0] byte_lsb(input int unsigned i);
    return BIT_IDX_W'(AES_BLOCK_BITS - 8 - 8 * i);
  endfunction

endpackage

// File: rtl/aes_sbox_cell.sv
// Combinational AES S-box cell: forward table, plus the inverse table when
// INVERSE_EN is set.
module aes_sbox_cell #(
  parameter bit INVERSE_EN = 1'b1
) (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  localparam logic [0:255][7:0] FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  if (INVERSE_EN) begin : g_inv
    assign dout = inv ? INV_TBL[din] : FWD_TBL[din];
  end else begin : g_fwd_only
    // Mode select has no effect without the inverse table.
    logic unused_inv;
    assign unused_inv = inv;
    assign dout       = FWD_TBL[din];
  end

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes: substitutes a 128-bit state LANES bytes per cycle
// with valid/ready handshakes on input and output.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter bit          INVERSE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned STEPS = AES_BLOCK_BYTES / LANES;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned LAST  = STEPS - 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  sub_bytes_state_e        state_q, state_d;
  logic [127:0]            blk_q, blk_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic [31:0]             base;
  logic [7:0]              lane_in  [LANES];
  logic [7:0]              lane_out [LANES];

  assign base     = 32'(cnt_q) * LANES;
  assign out_data = blk_q;

  // Slice mux and S-box cells for the current chunk.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = blk_q[byte_lsb(base + l) +: 8];

    aes_sbox_cell #(
      .INVERSE_EN(INVERSE_EN)
    ) u_cell (
      .din (lane_in[l]),
      .inv (mode_q),
      .dout(lane_out[l])
    );
  end

  // Next-state, datapath update and in_ready.
  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    in_ready = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = in_data;
          mode_d  = in_inv & INVERSE_EN;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          blk_d[byte_lsb(base + 32'(l)) +: 8] = lane_out[l];
        end
        if (cnt_q == CNT_W'(LAST)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // Back-to-back accept when the finished block is consumed.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            blk_d   = in_data;
            mode_d  = in_inv & INVERSE_EN;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      blk_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      out_valid <= (state_d == DONE);
      busy      <= (state_d == RUN);
    end
  end

endmodule
